// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS datapath (shared ALU, unified memory).
// Decodes op/funct from the instruction register and sequences the
// datapath one state per cycle. Memory states wait on mem_ready.
module multicycle_ctrl #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       halted
);

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU function codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B select
  localparam logic [1:0] B_REG  = 2'b00;
  localparam logic [1:0] B_FOUR = 2'b01;
  localparam logic [1:0] B_IMM  = 2'b10;
  localparam logic [1:0] B_IMM4 = 2'b11;

  // PC source select
  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_OUT  = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  // all control outputs bundled so the reset override is one assignment
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       halted;
  } ctl_t;

  state_t state, state_nx;
  ctl_t   ctl_st, ctl;

  logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, op_legal;
  logic       funct_ok;
  logic [2:0] alu_fn;
  logic       nop_on_illegal;

  assign nop_on_illegal = (TRAP_ON_ILLEGAL == 1'b0);

  // opcode classification
  always_comb begin
    is_rtype = (op == OP_RTYPE);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_addi  = (op == OP_ADDI);
    is_j     = (op == OP_J);
    op_legal = is_rtype | is_lw | is_sw | is_beq | is_addi | is_j;
  end

  // R-type funct to ALU function; unknown funct flagged illegal
  always_comb begin
    funct_ok = 1'b1;
    alu_fn   = ALU_ADD;
    case (funct)
      FN_ADD:  alu_fn = ALU_ADD;
      FN_SUB:  alu_fn = ALU_SUB;
      FN_AND:  alu_fn = ALU_AND;
      FN_OR:   alu_fn = ALU_OR;
      FN_SLT:  alu_fn = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // state register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        if (is_lw || is_sw)  state_nx = S_MEMADR;
        else if (is_rtype)   state_nx = S_EXECUTE;
        else if (is_beq)     state_nx = S_BRANCH;
        else if (is_addi)    state_nx = S_ADDIEXEC;
        else if (is_j)       state_nx = S_JUMP;
        else                 state_nx = nop_on_illegal ? S_FETCH : S_HALT;
      end
      S_MEMADR:   state_nx = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready) state_nx = S_MEMWB;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWR:    if (mem_ready) state_nx = S_FETCH;
      // bad funct is caught here; ALUWB is never reached so no regwrite
      S_EXECUTE: begin
        if (funct_ok)            state_nx = S_ALUWB;
        else if (nop_on_illegal) state_nx = S_FETCH;
        else                     state_nx = S_HALT;
      end
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_ADDIEXEC: state_nx = S_ADDIWB;
      S_ADDIWB:   state_nx = S_FETCH;
      S_JUMP:     state_nx = S_FETCH;
      S_HALT:     state_nx = S_HALT;
      default:    state_nx = S_FETCH;
    endcase
  end

  // per-state outputs; only pcen (zero) and memory enables (mem_ready) are Mealy
  always_comb begin
    ctl_st            = '0;
    ctl_st.alucontrol = ALU_ADD;
    case (state)
      S_FETCH: begin
        ctl_st.mem_req = 1'b1;
        ctl_st.alusrcb = B_FOUR;
        ctl_st.pcsrc   = PC_ALU;
        ctl_st.irwrite = mem_ready;
        ctl_st.pcen    = mem_ready;
      end
      S_DECODE: begin
        ctl_st.alusrcb    = B_IMM4;
        ctl_st.instr_done = nop_on_illegal & ~op_legal;
      end
      S_MEMADR: begin
        ctl_st.alusrca = 1'b1;
        ctl_st.alusrcb = B_IMM;
      end
      S_MEMRD: begin
        ctl_st.mem_req = 1'b1;
        ctl_st.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctl_st.memtoreg   = 1'b1;
        ctl_st.regwrite   = 1'b1;
        ctl_st.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctl_st.mem_req    = 1'b1;
        ctl_st.iord       = 1'b1;
        ctl_st.memwrite   = 1'b1;
        ctl_st.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctl_st.alusrca    = 1'b1;
        ctl_st.alusrcb    = B_REG;
        ctl_st.alucontrol = alu_fn;
        ctl_st.instr_done = nop_on_illegal & ~funct_ok;
      end
      S_ALUWB: begin
        ctl_st.regdst     = 1'b1;
        ctl_st.regwrite   = 1'b1;
        ctl_st.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctl_st.alusrca    = 1'b1;
        ctl_st.alusrcb    = B_REG;
        ctl_st.alucontrol = ALU_SUB;
        ctl_st.pcsrc      = PC_OUT;
        ctl_st.pcen       = zero;
        ctl_st.instr_done = 1'b1;
      end
      S_ADDIEXEC: begin
        ctl_st.alusrca = 1'b1;
        ctl_st.alusrcb = B_IMM;
      end
      S_ADDIWB: begin
        ctl_st.regwrite   = 1'b1;
        ctl_st.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctl_st.pcsrc      = PC_JUMP;
        ctl_st.pcen       = 1'b1;
        ctl_st.instr_done = 1'b1;
      end
      S_HALT:  ctl_st.halted = 1'b1;
      default: ;
    endcase
  end

  // reset cycle: FETCH-style selects, every write/enable suppressed
  always_comb begin
    ctl = ctl_st;
    if (!reset) begin
      ctl            = '0;
      ctl.alusrcb    = B_FOUR;
      ctl.pcsrc      = PC_ALU;
      ctl.alucontrol = ALU_ADD;
    end
  end

  assign mem_req    = ctl.mem_req;
  assign iord       = ctl.iord;
  assign memwrite   = ctl.memwrite;
  assign irwrite    = ctl.irwrite;
  assign regdst     = ctl.regdst;
  assign memtoreg   = ctl.memtoreg;
  assign regwrite   = ctl.regwrite;
  assign alusrca    = ctl.alusrca;
  assign alusrcb    = ctl.alusrcb;
  assign pcsrc      = ctl.pcsrc;
  assign pcen       = ctl.pcen;
  assign alucontrol = ctl.alucontrol;
  assign instr_done = ctl.instr_done;
  assign halted     = ctl.halted;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM that sequences a multicycle MIPS datapath: shared ALU, unified instruction/data memory, instruction register and ALUOut register. Decodes op/funct from the instruction register and, per state, drives the mux selects, write enables and ALU function. Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j. A memory-ready handshake lets slow memory stall the sequence.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: illegal op/funct enters HALT until reset; 0: illegal instruction retires as a NOP (DECODE -> FETCH).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising clk edge resets the FSM
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access this cycle
mem_req  out  1  memory access active (FETCH, MEMRD, MEMWR)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
regdst  out  1  write register: 0 = rt, 1 = rd
memtoreg  out  1  write-back data: 0 = ALUOut, 1 = memory data
regwrite  out  1  register file write enable
alusrca  out  1  ALU A: 0 = PC, 1 = reg A
alusrcb  out  2  ALU B: 00 = reg B, 01 = 4, 10 = signimm, 11 = signimm<<2
pcsrc  out  2  PC next: 00 = ALU result, 01 = ALUOut, 10 = jump target
pcen  out  1  PC load enable
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
halted  out  1  FSM is in HALT

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, HALT. Binary encoding. One state register.
- Outputs are Moore on state, except two terms. pcen in BRANCH is zero-qualified. Memory-state enables are qualified by mem_ready.
- Reset:
  - At a clk edge with reset==0, state <= FETCH.
  - While reset==0, memwrite, irwrite, regwrite, pcen, instr_done and mem_req are forced 0 combinationally.
  - All other outputs take their FETCH values: iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010, regdst=0, memtoreg=0, halted=0.
- Reset mid-instruction aborts it. No partial write may occur in the reset cycle.
- Unlisted outputs are 0 in each state. alucontrol is 010 unless stated.
- FETCH:
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11 (branch target into ALUOut).
  - Next state: lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEXEC; j -> JUMP.
  - Illegal op -> HALT (TRAP_ON_ILLEGAL=1) or FETCH with instr_done=1 (TRAP_ON_ILLEGAL=0).
- MEMADR: alusrca=1, alusrcb=10. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Next FETCH.
- MEMWR:
  - Outputs: mem_req=1, iord=1, memwrite=1 held every cycle until mem_ready.
  - instr_done=mem_ready. Go to FETCH on mem_ready.
- EXECUTE:
  - Outputs: alusrca=1, alusrcb=00.
  - alucontrol from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Next state ALUWB. Any other funct is illegal, handled per TRAP_ON_ILLEGAL; in that case regwrite is never asserted.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1. Next FETCH.
- BRANCH:
  - Outputs: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero, instr_done=1.
  - Next FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, alucontrol=010. Next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Next FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1. Next FETCH.
- HALT:
  - Outputs: halted=1; all enables and mem_req 0.
  - Exit only via reset.
- Latency with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each cycle mem_ready=0 in a memory state adds 1.
- Simultaneous events: reset==0 overrides mem_ready and every decode. A mem_ready that arrives in a non-memory state is ignored.

Test Plan:
1. Reset low 2 cycles, then high; mem_ready=1; op=100011 (lw) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles); regwrite=1 and memtoreg=1 only in cycle 5; instr_done pulses once.
2. op=000000, funct=101010 -> EXECUTE drives alucontrol=111, alusrcb=00; ALUWB asserts regdst=1, regwrite=1; 4 cycles total.
3. op=000100 (beq) with zero=1 -> pcen=1, pcsrc=01 in BRANCH; repeat with zero=0 -> pcen=0; both return to FETCH after 3 cycles.
4. mem_ready held 0 for 3 cycles in FETCH -> state stays FETCH, irwrite=pcen=0, mem_req=1. Then mem_ready=1 -> irwrite=pcen=1 for exactly 1 cycle, next state DECODE.
5. sw with mem_ready=0 for 2 cycles in MEMWR -> memwrite=1 for 3 consecutive cycles; instr_done only in the 3rd. Repeat with reset=0 in the 2nd MEMWR cycle -> memwrite=0 that cycle, next state FETCH.
6. op=111111 with TRAP_ON_ILLEGAL=1 -> HALT, halted=1, no enables for 10 cycles. With TRAP_ON_ILLEGAL=0 -> FETCH after DECODE, instr_done=1, regwrite never asserted.
